// File: rtl/uart_sram_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_sram_stream_loader_if
// Brief    : UART receive handshake plus SRAM write port seen by the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_sram_stream_loader_if #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 16
);
   logic [7:0]            RX_data;
   logic                  RX_empty;
   logic                  RX_enable;
   logic                  RX_unload;
   logic [ADDR_WIDTH-1:0] SRAM_address;
   logic [DATA_WIDTH-1:0] SRAM_write_data;
   logic                  SRAM_we_n;

   modport master (
      input  RX_data, RX_empty,
      output RX_enable, RX_unload, SRAM_address, SRAM_write_data, SRAM_we_n
   );

   modport slave (
      output RX_data, RX_empty,
      input  RX_enable, RX_unload, SRAM_address, SRAM_write_data, SRAM_we_n
   );
endinterface
`default_nettype wire

// File: rtl/uart_sram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_sram_stream_loader
// Brief    : Strips an optional N-line header from a UART byte stream, packs
//            bytes into words and writes them to consecutive SRAM addresses.
//            Define UART_SRAM_CHECKSUM_EN to add a running word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sram_stream_loader #(
   parameter int                    ADDR_WIDTH   = 18,
   parameter int                    DATA_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] END_ADDR     = ADDR_WIDTH'(18'h3FFFF),
   parameter int                    HEADER_LINES = 0,
   parameter int                    BIG_ENDIAN   = 1
) (
   input  logic                    Clock,
   input  logic                    Resetn,
   input  logic                    Initialize,
   input  logic                    Enable,
   input  logic [ADDR_WIDTH-1:0]   Start_address,
   uart_sram_stream_loader_if.master bus,
   output logic [ADDR_WIDTH:0]     Word_count,
   output logic                    Busy,
   output logic                    Done
`ifdef UART_SRAM_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]   Checksum
`endif
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int HC_W  = (HEADER_LINES > 0) ? $clog2(HEADER_LINES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HDR_WAIT  = 3'd1,
      S_HDR_ACK   = 3'd2,
      S_BYTE_WAIT = 3'd3,
      S_BYTE_ACK  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t                state_q,     state_d;
   logic                  rx_enable_q, rx_enable_d;
   logic                  rx_unload_q, rx_unload_d;
   logic                  we_n_q,      we_n_d;
   logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
   logic [DATA_WIDTH-1:0] asm_q,       asm_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [ADDR_WIDTH:0]   count_q,     count_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic [HC_W-1:0]       hdr_cnt_q,   hdr_cnt_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;
`ifdef UART_SRAM_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q,      csum_d;
`endif

   logic [IDX_W-1:0]      lane;
   logic                  last_byte;
   logic [DATA_WIDTH-1:0] word_next;

   assign lane      = (BIG_ENDIAN != 0) ? (IDX_W'(BYTES - 1) - idx_q) : idx_q;
   assign last_byte = (idx_q == IDX_W'(BYTES - 1));

   always_comb begin
      state_d     = state_q;
      rx_enable_d = rx_enable_q;
      rx_unload_d = rx_unload_q;
      we_n_d      = we_n_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      addr_d      = addr_q;
      count_d     = count_q;
      idx_d       = idx_q;
      hdr_cnt_d   = hdr_cnt_q;
`ifdef UART_SRAM_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      // Word as it would look with the byte now on RX_data dropped into its lane.
      word_next = asm_q;
      for (int b = 0; b < BYTES; b++) begin
         if (lane == IDX_W'(b)) word_next[b*8 +: 8] = bus.RX_data;
      end

      case (state_q)
         S_IDLE: begin
            if (Enable) begin
               addr_d    = Start_address;
               count_d   = '0;
               hdr_cnt_d = '0;
`ifdef UART_SRAM_CHECKSUM_EN
               csum_d    = '0;
`endif
               if (Start_address > END_ADDR) begin
                  state_d = S_DONE;
               end else begin
                  rx_enable_d = 1'b1;
                  state_d     = (HEADER_LINES > 0) ? S_HDR_WAIT : S_BYTE_WAIT;
               end
            end
         end
         S_HDR_WAIT: begin
            if (!bus.RX_empty) begin
               rx_unload_d = 1'b1;
               if (bus.RX_data == 8'h0A) hdr_cnt_d = hdr_cnt_q + HC_W'(1);
               state_d = S_HDR_ACK;
            end
         end
         S_HDR_ACK: begin
            if (bus.RX_empty) begin
               rx_unload_d = 1'b0;
               state_d     = (hdr_cnt_q == HC_W'(HEADER_LINES)) ? S_BYTE_WAIT : S_HDR_WAIT;
            end
         end
         S_BYTE_WAIT: begin
            if (!bus.RX_empty) begin
               rx_unload_d = 1'b1;
               asm_d       = word_next;
               if (last_byte) begin
                  wdata_d = word_next;
                  we_n_d  = 1'b0;
`ifdef UART_SRAM_CHECKSUM_EN
                  csum_d  = csum_q + word_next;
`endif
               end
               state_d = S_BYTE_ACK;
            end
         end
         S_BYTE_ACK: begin
            we_n_d = 1'b1;
            if (bus.RX_empty) begin
               rx_unload_d = 1'b0;
               if (!last_byte) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_BYTE_WAIT;
               end else begin
                  count_d = count_q + (ADDR_WIDTH+1)'(1);
                  idx_d   = '0;
                  if (addr_q == END_ADDR) begin
                     rx_enable_d = 1'b0;
                     state_d     = S_DONE;
                  end else begin
                     addr_d  = addr_q + ADDR_WIDTH'(1);
                     state_d = S_BYTE_WAIT;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Initialize discards any partial word and returns to the reset image.
      if (Initialize) begin
         state_d     = S_IDLE;
         rx_enable_d = 1'b0;
         rx_unload_d = 1'b0;
         we_n_d      = 1'b1;
         wdata_d     = '0;
         asm_d       = '0;
         addr_d      = '0;
         count_d     = '0;
         idx_d       = '0;
         hdr_cnt_d   = '0;
`ifdef UART_SRAM_CHECKSUM_EN
         csum_d      = '0;
`endif
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= S_IDLE;
         rx_enable_q <= 1'b0;
         rx_unload_q <= 1'b0;
         we_n_q      <= 1'b1;
         wdata_q     <= '0;
         asm_q       <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         hdr_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef UART_SRAM_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rx_enable_q <= rx_enable_d;
         rx_unload_q <= rx_unload_d;
         we_n_q      <= we_n_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         hdr_cnt_q   <= hdr_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef UART_SRAM_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.RX_enable       = rx_enable_q;
   assign bus.RX_unload       = rx_unload_q;
   assign bus.SRAM_address    = addr_q;
   assign bus.SRAM_write_data = wdata_q;
   assign bus.SRAM_we_n       = we_n_q;
   assign Word_count          = count_q;
   assign Busy                = busy_q;
   assign Done                = done_q;
`ifdef UART_SRAM_CHECKSUM_EN
   assign Checksum            = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_sram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sram_stream_loader
// Brief    : Two loader instances (16-bit big-endian, and 32-bit little-endian
//            with a 3-line header and END_ADDR=5) driven by random byte streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sram_stream_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        init, ena_a, ena_b;
   logic [17:0] start_a, start_b;
   logic [18:0] wc_a, wc_b;
   logic        busy_a, busy_b, done_a, done_b;
`ifdef UART_SRAM_CHECKSUM_EN
   logic [15:0] cs_a;
   logic [31:0] cs_b;
`endif

   uart_sram_stream_loader_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) ifa ();
   uart_sram_stream_loader_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ifb ();

   uart_sram_stream_loader dut_a (
      .Clock(clk), .Resetn(rst_n), .Initialize(init), .Enable(ena_a),
      .Start_address(start_a), .bus(ifa.master), .Word_count(wc_a),
      .Busy(busy_a), .Done(done_a)
`ifdef UART_SRAM_CHECKSUM_EN
      , .Checksum(cs_a)
`endif
   );

   uart_sram_stream_loader #(
      .ADDR_WIDTH(18), .DATA_WIDTH(32), .END_ADDR(18'd5),
      .HEADER_LINES(3), .BIG_ENDIAN(0)
   ) dut_b (
      .Clock(clk), .Resetn(rst_n), .Initialize(init), .Enable(ena_b),
      .Start_address(start_b), .bus(ifb.master), .Word_count(wc_b),
      .Busy(busy_b), .Done(done_b)
`ifdef UART_SRAM_CHECKSUM_EN
      , .Checksum(cs_b)
`endif
   );

   typedef struct packed {
      logic [17:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        wr_a[$];
   wr_t        wr_b[$];
   logic [7:0] stim[$];
   int         n_checks;
   int         n_pass;
   int         wide_cnt;
   bit         prev_a, prev_b;

   // Write monitor: records every strobe and counts strobes longer than a cycle.
   always @(negedge clk) begin
      if (ifa.SRAM_we_n === 1'b0) begin
         wr_a.push_back({ifa.SRAM_address, 16'h0, ifa.SRAM_write_data});
         if (prev_a) wide_cnt++;
      end
      if (ifb.SRAM_we_n === 1'b0) begin
         wr_b.push_back({ifb.SRAM_address, ifb.SRAM_write_data});
         if (prev_b) wide_cnt++;
      end
      prev_a = (ifa.SRAM_we_n === 1'b0);
      prev_b = (ifb.SRAM_we_n === 1'b0);
   end

   function automatic logic rx_unload(input int sel);
      return (sel == 0) ? ifa.RX_unload : ifb.RX_unload;
   endfunction

   task automatic drive_rx(input int sel, input logic [7:0] d, input logic empty);
      if (sel == 0) begin
         ifa.RX_data = d; ifa.RX_empty = empty;
      end else begin
         ifb.RX_data = d; ifb.RX_empty = empty;
      end
   endtask

   // Receiver model: present a byte, wait (bounded) for the 4-phase unload.
   task automatic send_byte(input int sel, input logic [7:0] d, output bit taken, output bit hung);
      taken = 1'b0;
      hung  = 1'b0;
      drive_rx(sel, d, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rx_unload(sel) === 1'b1) begin
            taken = 1'b1;
            break;
         end
      end
      drive_rx(sel, d, 1'b1);
      if (taken) begin
         hung = 1'b1;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_unload(sel) === 1'b0) begin
               hung = 1'b0;
               break;
            end
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic push_header();
      string h = "P5\n2 2\n255\n";
      for (int i = 0; i < h.len(); i++) stim.push_back(h[i]);
   endtask

   task automatic pulse_init();
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
   endtask

   // Runs the stream in stim through one instance and compares with the model.
   task automatic run_and_check(input int sel, input logic [17:0] start, input string name);
      int          bpw   = (sel != 0) ? 4 : 2;
      bit          big   = (sel == 0);
      int          hdr   = (sel != 0) ? 3 : 0;
      int          end_a = (sel != 0) ? 5 : 'h3FFFF;
      int          st    = int'(start);
      int          hdr_len, nl, pay, exp_words, consumed, got, hangs, exp_addr, nwr;
      bit          exp_done, taken, hung;
      logic [31:0] exp_data[$];
      logic [31:0] word;
      wr_t         w;
      logic [18:0] obs_wc;
      logic [17:0] obs_addr;
      logic        obs_done, obs_busy, obs_en;
`ifdef UART_SRAM_CHECKSUM_EN
      logic [31:0] exp_cs, obs_cs;
`endif

      hdr_len = 0;
      nl      = 0;
      while (nl < hdr && hdr_len < stim.size()) begin
         if (stim[hdr_len] == 8'h0A) nl++;
         hdr_len++;
      end
      pay = stim.size() - hdr_len;
      if (st > end_a) begin
         exp_words = 0; consumed = 0; exp_done = 1'b1; exp_addr = st;
      end else begin
         exp_words = pay / bpw;
         exp_done  = 1'b0;
         consumed  = stim.size();
         if (exp_words >= end_a - st + 1) begin
            exp_words = end_a - st + 1;
            exp_done  = 1'b1;
            consumed  = hdr_len + exp_words * bpw;
            exp_addr  = end_a;
         end else begin
            exp_addr  = st + exp_words;
         end
      end
`ifdef UART_SRAM_CHECKSUM_EN
      exp_cs = 0;
`endif
      for (int k = 0; k < exp_words; k++) begin
         word = 0;
         for (int j = 0; j < bpw; j++)
            word = word | (32'(stim[hdr_len + k*bpw + j]) << (8 * (big ? (bpw - 1 - j) : j)));
         exp_data.push_back(word);
`ifdef UART_SRAM_CHECKSUM_EN
         exp_cs = exp_cs + word;
         if (bpw == 2) exp_cs = exp_cs & 32'hFFFF;
`endif
      end

      wr_a.delete();
      wr_b.delete();
      wide_cnt = 0;
      if (sel == 0) begin start_a = start; ena_a = 1'b1; end
      else          begin start_b = start; ena_b = 1'b1; end
      @(negedge clk);
      ena_a = 1'b0;
      ena_b = 1'b0;
      obs_done = (sel != 0) ? done_b : done_a;
      n_checks++;
      if (obs_done !== (st > end_a))
         $display("FAIL %s done_after_enable: got %b want %b", name, obs_done, (st > end_a));
      else n_pass++;

      got   = 0;
      hangs = 0;
      for (int i = 0; i < stim.size(); i++) begin
         send_byte(sel, stim[i], taken, hung);
         if (hung) hangs++;
         if (!taken) break;
         got++;
      end
      repeat (3) @(negedge clk);

      n_checks++;
      if (got !== consumed) $display("FAIL %s bytes_unloaded: got %0d want %0d", name, got, consumed);
      else n_pass++;
      n_checks++;
      if (hangs !== 0) $display("FAIL %s unload_release_timeout: got %0d want 0", name, hangs);
      else n_pass++;

      nwr = (sel != 0) ? wr_b.size() : wr_a.size();
      n_checks++;
      if (nwr !== exp_words) $display("FAIL %s write_count: got %0d want %0d", name, nwr, exp_words);
      else n_pass++;
      for (int k = 0; k < exp_words && k < nwr; k++) begin
         w = (sel != 0) ? wr_b[k] : wr_a[k];
         n_checks++;
         if (w.addr !== 18'(st + k) || w.data !== exp_data[k])
            $display("FAIL %s write[%0d]: got %h@%h want %h@%h", name, k, w.data, w.addr, exp_data[k], 18'(st + k));
         else n_pass++;
      end
      n_checks++;
      if (wide_cnt !== 0) $display("FAIL %s we_n_pulse_width: got %0d extra cycles want 0", name, wide_cnt);
      else n_pass++;

      obs_wc   = (sel != 0) ? wc_b : wc_a;
      obs_addr = (sel != 0) ? ifb.SRAM_address : ifa.SRAM_address;
      obs_done = (sel != 0) ? done_b : done_a;
      obs_busy = (sel != 0) ? busy_b : busy_a;
      obs_en   = (sel != 0) ? ifb.RX_enable : ifa.RX_enable;
      n_checks++;
      if (obs_wc !== 19'(exp_words)) $display("FAIL %s word_count: got %0d want %0d", name, obs_wc, exp_words);
      else n_pass++;
      n_checks++;
      if (obs_addr !== 18'(exp_addr)) $display("FAIL %s final_address: got %h want %h", name, obs_addr, 18'(exp_addr));
      else n_pass++;
      n_checks++;
      if ({obs_done, obs_busy, obs_en} !== {exp_done, !exp_done, !exp_done})
         $display("FAIL %s done_busy_rxen: got %b%b%b want %b%b%b", name, obs_done, obs_busy, obs_en,
                  exp_done, !exp_done, !exp_done);
      else n_pass++;
`ifdef UART_SRAM_CHECKSUM_EN
      obs_cs = (sel != 0) ? cs_b : {16'h0, cs_a};
      n_checks++;
      if (obs_cs !== exp_cs) $display("FAIL %s checksum: got %h want %h", name, obs_cs, exp_cs);
      else n_pass++;
`endif

      // A finished run must ignore a further Enable.
      if (exp_done) begin
         if (sel == 0) begin start_a = start ^ 18'h1; ena_a = 1'b1; end
         else          begin start_b = start ^ 18'h1; ena_b = 1'b1; end
         @(negedge clk);
         ena_a = 1'b0;
         ena_b = 1'b0;
         repeat (2) @(negedge clk);
         obs_addr = (sel != 0) ? ifb.SRAM_address : ifa.SRAM_address;
         obs_done = (sel != 0) ? done_b : done_a;
         n_checks++;
         if (obs_addr !== 18'(exp_addr) || obs_done !== 1'b1)
            $display("FAIL %s enable_in_done: got addr %h done %b want addr %h done 1", name, obs_addr, obs_done,
                     18'(exp_addr));
         else n_pass++;
      end
      pulse_init();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({ifa.RX_enable, ifa.RX_unload, ifa.SRAM_we_n, busy_a, done_a} !== 5'b00100)
         $display("FAIL reset_ctrl_a: got %b want 00100",
                  {ifa.RX_enable, ifa.RX_unload, ifa.SRAM_we_n, busy_a, done_a});
      else n_pass++;
      n_checks++;
      if (ifa.SRAM_address !== 18'h0 || ifa.SRAM_write_data !== 16'h0 || wc_a !== 19'h0)
         $display("FAIL reset_data_a: got addr %h data %h wc %h want 0 0 0", ifa.SRAM_address, ifa.SRAM_write_data, wc_a);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({ifb.RX_enable, ifb.RX_unload, ifb.SRAM_we_n, busy_b, done_b} !== 5'b00100 || ifb.SRAM_write_data !== 32'h0)
         $display("FAIL reset_idle_b: got %b data %h want 00100 data 0",
                  {ifb.RX_enable, ifb.RX_unload, ifb.SRAM_we_n, busy_b, done_b}, ifb.SRAM_write_data);
      else n_pass++;
   endtask

   task automatic test_basic_words();
      stim = '{8'hAB, 8'hCD, 8'h12, 8'h34};
      run_and_check(0, 18'd76800, "be16_abcd");
      stim = '{8'h00, 8'h01, 8'hFF, 8'hFF};
      run_and_check(0, 18'd100, "be16_wrap_sum");
   endtask

   task automatic test_little_endian_header();
      stim.delete();
      push_header();
      stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
      run_and_check(1, 18'd0, "le32_header");
   endtask

   task automatic test_end_addr();
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
      run_and_check(0, 18'h3FFFE, "end_addr_a");
      stim.delete();
      push_header();
      for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
      run_and_check(1, 18'd4, "end_addr_b");
   endtask

   task automatic test_start_past_end();
      stim.delete();
      push_header();
      stim.push_back(8'h55);
      run_and_check(1, 18'd6, "start_past_end");
   endtask

   task automatic test_initialize();
      bit taken, hung;
      wr_a.delete();
      start_a = 18'($urandom_range(0, 'h3FF00));
      ena_a   = 1'b1;
      @(negedge clk);
      ena_a = 1'b0;
      send_byte(0, 8'($urandom), taken, hung);
      pulse_init();
      n_checks++;
      if ({ifa.RX_enable, ifa.RX_unload, ifa.SRAM_we_n, busy_a, done_a} !== 5'b00100 ||
          ifa.SRAM_address !== 18'h0 || ifa.SRAM_write_data !== 16'h0 || wc_a !== 19'h0)
         $display("FAIL init_abort: got ctrl %b addr %h data %h wc %h want 00100 0 0 0",
                  {ifa.RX_enable, ifa.RX_unload, ifa.SRAM_we_n, busy_a, done_a},
                  ifa.SRAM_address, ifa.SRAM_write_data, wc_a);
      else n_pass++;
      n_checks++;
      if (wr_a.size() !== 0 || taken !== 1'b1)
         $display("FAIL init_no_write: got writes %0d taken %b want 0 1", wr_a.size(), taken);
      else n_pass++;
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
      run_and_check(0, 18'($urandom_range(0, 'h3FF00)), "after_init");
   endtask

   task automatic test_random();
      int sel;
      for (int r = 0; r < 6; r++) begin
         sel = r % 2;
         stim.delete();
         if (sel != 0) push_header();
         for (int i = 0; i < int'($urandom_range(1, 13)); i++) stim.push_back(8'($urandom));
         if (sel == 0) run_and_check(0, 18'($urandom_range(0, 'h3FFF0)), "random_a");
         else          run_and_check(1, 18'($urandom_range(0, 5)), "random_b");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      wide_cnt = 0;
      init     = 1'b0;
      ena_a    = 1'b0;
      ena_b    = 1'b0;
      start_a  = '0;
      start_b  = '0;
      drive_rx(0, 8'h00, 1'b1);
      drive_rx(1, 8'h00, 1'b1);
      test_reset();
      test_basic_words();
      test_little_endian_header();
      test_end_addr();
      test_start_past_end();
      test_initialize();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
